// File: rtl/rv_core_pkg.sv
// Core-wide constants and the writeback request record shared by the
// writeback and long-latency stages.
package rv_core_pkg;
  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;

  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] wa;
    logic [XLEN-1:0]       wd;
  } wb_req_t;
endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Valid/ready writeback request channel; one instance per writer.
interface regfile_wb_arbiter_if
  import rv_core_pkg::*;
  ();
  wb_req_t req;
  logic    ready;

  modport master (output req, input ready);
  modport slave  (input req, output ready);
endinterface

// File: rtl/wb_scoreboard.sv
// Busy bitmap of registers awaiting a long-latency write, with three
// combinational lookup ports. x0 can never become busy.
module wb_scoreboard
  import rv_core_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  set_en,
  input  logic [REG_ADDR_W-1:0] set_idx,
  input  logic                  clr_en,
  input  logic [REG_ADDR_W-1:0] clr_idx,
  input  logic [REG_ADDR_W-1:0] look_a,
  input  logic [REG_ADDR_W-1:0] look_b,
  input  logic [REG_ADDR_W-1:0] look_c,
  output logic                  busy_a,
  output logic                  busy_b,
  output logic                  busy_c,
  output logic [NUM_REGS-1:0]   busy
);
  localparam logic [NUM_REGS-1:0] ONE_HOT0 = {{(NUM_REGS-1){1'b0}}, 1'b1};

  logic [NUM_REGS-1:0] busy_r;
  logic [NUM_REGS-1:0] set_mask_s;
  logic [NUM_REGS-1:0] clr_mask_s;
  logic [NUM_REGS-1:0] busy_nxt_s;

  // Next bitmap: the set mask is applied after the clear, so set wins on a tie.
  always_comb begin
    set_mask_s = set_en ? (ONE_HOT0 << set_idx) : {NUM_REGS{1'b0}};
    set_mask_s = set_mask_s & ~ONE_HOT0;
    clr_mask_s = clr_en ? (ONE_HOT0 << clr_idx) : {NUM_REGS{1'b0}};
    busy_nxt_s = (busy_r & ~clr_mask_s) | set_mask_s;
  end

  // Bitmap register.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_r <= {NUM_REGS{1'b0}};
    end else begin
      busy_r <= busy_nxt_s;
    end
  end

  assign busy_a = busy_r[look_a];
  assign busy_b = busy_r[look_b];
  assign busy_c = busy_r[look_c];
  assign busy   = busy_r;
endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the register file write port between the pipeline writeback and the
// long-latency unit, with a starvation guard and an lu-write scoreboard.
module regfile_wb_arbiter
  import rv_core_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  regfile_wb_arbiter_if.slave         pipe,
  regfile_wb_arbiter_if.slave         lu,
  input  logic                        lu_issue,
  input  logic [REG_ADDR_W-1:0]       lu_issue_rd,
  input  logic [REG_ADDR_W-1:0]       chk_ra1,
  input  logic [REG_ADDR_W-1:0]       chk_ra2,
  input  logic [REG_ADDR_W-1:0]       chk_rd,
  output logic                        hazard,
  output logic                        rf_we,
  output logic [REG_ADDR_W-1:0]       rf_wa,
  output logic [XLEN-1:0]             rf_wd,
  output logic [NUM_REGS-1:0]         sb_busy
);
  localparam int                CNT_W      = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0]  STARVE_LIM = CNT_W'(STARVE_MAX);

  logic [CNT_W-1:0]      starve_cnt_r;
  logic [CNT_W-1:0]      starve_nxt_s;
  logic                  src_lu_r;
  logic                  override_s;
  logic                  pipe_hs_s;
  logic                  lu_hs_s;
  logic [REG_ADDR_W-1:0] sel_wa_s;
  logic [XLEN-1:0]       sel_wd_s;
  logic                  busy_a_s;
  logic                  busy_b_s;
  logic                  busy_c_s;

  assign override_s = (starve_cnt_r == STARVE_LIM) && lu.req.valid;
  assign pipe.ready = !override_s;
  assign lu.ready   = override_s || !pipe.req.valid;
  assign pipe_hs_s  = pipe.req.valid && pipe.ready;
  assign lu_hs_s    = lu.req.valid && lu.ready;

  // Grant selection and starvation counter update.
  always_comb begin
    sel_wa_s = lu_hs_s ? lu.req.wa : pipe.req.wa;
    sel_wd_s = lu_hs_s ? lu.req.wd : pipe.req.wd;
    if (!lu.req.valid || lu_hs_s) begin
      starve_nxt_s = {CNT_W{1'b0}};
    end else if (pipe.req.valid && !override_s && (starve_cnt_r != STARVE_LIM)) begin
      starve_nxt_s = starve_cnt_r + CNT_W'(1'b1);
    end else begin
      starve_nxt_s = starve_cnt_r;
    end
  end

  // Registered write port; address/data hold when no handshake occurs.
  always_ff @(posedge clk) begin
    if (rst) begin
      rf_we        <= 1'b0;
      rf_wa        <= {REG_ADDR_W{1'b0}};
      rf_wd        <= {XLEN{1'b0}};
      src_lu_r     <= 1'b0;
      starve_cnt_r <= {CNT_W{1'b0}};
    end else begin
      starve_cnt_r <= starve_nxt_s;
      if (pipe_hs_s || lu_hs_s) begin
        rf_we    <= (sel_wa_s != {REG_ADDR_W{1'b0}});
        rf_wa    <= sel_wa_s;
        rf_wd    <= sel_wd_s;
        src_lu_r <= lu_hs_s;
      end else begin
        rf_we    <= 1'b0;
      end
    end
  end

  // Busy drops on the same edge the register file commits the lu result.
  wb_scoreboard u_sb (
    .clk     (clk),
    .rst     (rst),
    .set_en  (lu_issue),
    .set_idx (lu_issue_rd),
    .clr_en  (rf_we && src_lu_r),
    .clr_idx (rf_wa),
    .look_a  (chk_ra1),
    .look_b  (chk_ra2),
    .look_c  (chk_rd),
    .busy_a  (busy_a_s),
    .busy_b  (busy_b_s),
    .busy_c  (busy_c_s),
    .busy    (sb_busy)
  );

  assign hazard = busy_a_s || busy_b_s || busy_c_s;
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: a cycle model predicts readies,
// hazard and the scoreboard; expected writes are queued at handshake time.
module tb_regfile_wb_arbiter;
  import rv_core_pkg::*;

  localparam int SM = 4;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  lu_issue;
  logic [REG_ADDR_W-1:0] lu_issue_rd, chk_ra1, chk_ra2, chk_rd;
  logic                  hazard, rf_we;
  logic [REG_ADDR_W-1:0] rf_wa;
  logic [XLEN-1:0]       rf_wd;
  logic [NUM_REGS-1:0]   sb_busy;

  always #5 clk = ~clk;

  regfile_wb_arbiter_if pipe_if ();
  regfile_wb_arbiter_if lu_if ();

  regfile_wb_arbiter #(.STARVE_MAX(SM)) dut (
    .clk(clk), .rst(rst), .pipe(pipe_if), .lu(lu_if),
    .lu_issue(lu_issue), .lu_issue_rd(lu_issue_rd),
    .chk_ra1(chk_ra1), .chk_ra2(chk_ra2), .chk_rd(chk_rd),
    .hazard(hazard), .rf_we(rf_we), .rf_wa(rf_wa), .rf_wd(rf_wd),
    .sb_busy(sb_busy)
  );

  typedef struct {
    logic                  we;
    logic [REG_ADDR_W-1:0] wa;
    logic [XLEN-1:0]       wd;
    logic                  src;
  } wr_t;

  wr_t                 exp_q[$];
  wr_t                 cur;
  logic [NUM_REGS-1:0] m_busy;
  int                  m_cnt;
  int                  n_pass  = 0;
  int                  n_total = 0;
  logic                pipe_acc, lu_acc, obs_pr, obs_lr;
  int                  pipe_n, lu_n;

  // Protocol monitor: a pending request must not be withdrawn.
  logic pipe_pend = 1'b0, lu_pend = 1'b0;
  always @(posedge clk) begin
    if (!rst && pipe_pend && !pipe_if.req.valid) $error("FAIL protocol pipe valid dropped");
    if (!rst && lu_pend && !lu_if.req.valid) $error("FAIL protocol lu valid dropped");
    pipe_pend <= !rst && pipe_if.req.valid && !pipe_if.ready;
    lu_pend   <= !rst && lu_if.req.valid && !lu_if.ready;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_total++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
  endtask

  task automatic idle();
    pipe_if.req = '{1'b0, 5'd0, {XLEN{1'b0}}};
    lu_if.req   = '{1'b0, 5'd0, {XLEN{1'b0}}};
    lu_issue    = 1'b0;
    lu_issue_rd = 5'd0;
  endtask

  // One clock: check combinational outputs, predict, clock, check registered outputs.
  task automatic cycle();
    logic                ov, epr, elr, ehz;
    logic [NUM_REGS-1:0] nb;
    int                  nc;
    wr_t                 e;
    #1;
    ov  = (m_cnt == SM) && lu_if.req.valid;
    epr = !ov;
    elr = ov || !pipe_if.req.valid;
    ehz = m_busy[chk_ra1] | m_busy[chk_ra2] | m_busy[chk_rd];
    obs_pr = pipe_if.ready;
    obs_lr = lu_if.ready;
    chk("pipe_ready", pipe_if.ready, epr);
    chk("lu_ready", lu_if.ready, elr);
    chk("hazard", hazard, ehz);
    if (lu_issue) chk("issue_to_busy", sb_busy[lu_issue_rd], 1'b0);
    pipe_acc = pipe_if.req.valid && epr;
    lu_acc   = lu_if.req.valid && elr;
    if (!rst && (pipe_acc || lu_acc)) begin
      e.src = lu_acc;
      e.wa  = lu_acc ? lu_if.req.wa : pipe_if.req.wa;
      e.wd  = lu_acc ? lu_if.req.wd : pipe_if.req.wd;
      e.we  = (e.wa != 5'd0);
      exp_q.push_back(e);
    end
    nb = m_busy;
    if (cur.we && cur.src) nb[cur.wa] = 1'b0;
    if (lu_issue && lu_issue_rd != 5'd0) nb[lu_issue_rd] = 1'b1;
    if (!lu_if.req.valid || lu_acc) nc = 0;
    else if (pipe_if.req.valid && !ov && m_cnt < SM) nc = m_cnt + 1;
    else nc = m_cnt;
    @(posedge clk);
    #1;
    if (rst) begin
      m_busy = {NUM_REGS{1'b0}};
      m_cnt  = 0;
      exp_q.delete();
      cur = '{we: 1'b0, wa: 5'd0, wd: {XLEN{1'b0}}, src: 1'b0};
    end else begin
      m_busy = nb;
      m_cnt  = nc;
      if (exp_q.size() > 0) cur = exp_q.pop_front();
      else cur.we = 1'b0;
    end
    chk("rf_we", rf_we, cur.we);
    chk("rf_wa", rf_wa, cur.wa);
    chk("rf_wd", rf_wd, cur.wd);
    chk("sb_busy", sb_busy, m_busy);
  endtask

  initial begin
    cur    = '{we: 1'b0, wa: 5'd0, wd: {XLEN{1'b0}}, src: 1'b0};
    m_busy = {NUM_REGS{1'b0}};
    m_cnt  = 0;
    idle();
    chk_ra1 = 5'd0; chk_ra2 = 5'd0; chk_rd = 5'd0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    cycle();
    chk("reset_rf_we", rf_we, 1'b0);
    chk("reset_sb_busy", sb_busy, 32'd0);
    rst = 1'b0;

    // Pipe only
    pipe_if.req = '{1'b1, 5'd5, 32'hDEAD_BEEF};
    cycle();
    chk("pipe_only_ready", obs_pr, 1'b1);
    chk("pipe_only_we", {rf_we, rf_wa, rf_wd}, {1'b1, 5'd5, 32'hDEAD_BEEF});
    idle();
    cycle();
    chk("pipe_only_we_drop", rf_we, 1'b0);

    // x0 filter on issue and on both writers
    lu_issue = 1'b1; lu_issue_rd = 5'd0;
    cycle();
    idle();
    lu_if.req = '{1'b1, 5'd0, 32'h0000_0BAD};
    cycle();
    chk("x0_lu_accepted", obs_lr, 1'b1);
    chk("x0_we", rf_we, 1'b0);
    chk("x0_busy", sb_busy, 32'd0);
    idle();
    pipe_if.req = '{1'b1, 5'd0, 32'h0000_0BAD};
    cycle();
    idle();
    cycle();

    // Scoreboard set, hazard, clear on commit
    lu_issue = 1'b1; lu_issue_rd = 5'd7;
    cycle();
    chk("sb7_set", sb_busy[7], 1'b1);
    idle();
    chk_ra2 = 5'd7;
    cycle();
    lu_if.req = '{1'b1, 5'd7, 32'h0000_1234};
    cycle();
    chk("sb7_write", {rf_we, rf_wa, rf_wd}, {1'b1, 5'd7, 32'h0000_1234});
    idle();
    cycle();
    chk("sb7_clr", sb_busy[7], 1'b0);
    chk("sb7_hazard_clr", hazard, 1'b0);
    chk_ra2 = 5'd0;

    // Starvation: both requesting
    pipe_n = 0; lu_n = 0;
    for (int i = 0; i < 6; i++) begin
      pipe_if.req = '{1'b1, 5'(10 + pipe_n), 32'hA000_0000 + 32'(pipe_n)};
      lu_if.req   = '{1'b1, 5'(20 + lu_n), 32'hB000_0000 + 32'(lu_n)};
      cycle();
      chk($sformatf("starve_grant_%0d", i), {obs_pr, obs_lr}, (i == 4) ? 2'b01 : 2'b10);
      if (pipe_acc) pipe_n++;
      if (lu_acc) lu_n++;
    end
    pipe_if.req = '{1'b0, 5'd0, {XLEN{1'b0}}};
    cycle();
    chk("starve_lu_alone", {rf_we, rf_wa}, {1'b1, 5'd21});
    idle();
    cycle();

    // Set and clear of the same register on one edge
    lu_if.req = '{1'b1, 5'd9, 32'h0000_0099};
    cycle();
    idle();
    lu_issue = 1'b1; lu_issue_rd = 5'd9;
    cycle();
    chk("sb9_set_wins", sb_busy[9], 1'b1);
    idle();
    chk_rd = 5'd9;
    lu_if.req = '{1'b1, 5'd9, 32'h0000_0999};
    cycle();
    idle();
    cycle();
    cycle();
    chk("sb9_clr", sb_busy[9], 1'b0);
    chk_rd = 5'd0;

    // Reset while a write is registered
    lu_issue = 1'b1; lu_issue_rd = 5'd3;
    cycle();
    idle();
    pipe_if.req = '{1'b1, 5'd12, 32'hCAFE_F00D};
    cycle();
    idle();
    rst = 1'b1;
    cycle();
    chk("rst_mid_we", rf_we, 1'b0);
    chk("rst_mid_busy", sb_busy, 32'd0);
    rst = 1'b0;
    cycle();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
